// File: rtl/scan_updown_counter.sv
// -----------------------------------------------------------------------------
// scan_updown_counter
//
// Scanned multi-key up/down counter. A one-hot-low select walks across the keys.
// A single shared return line reports whether the selected key is pressed. Each
// key is debounced on its own sample. Debounced presses (and optional
// auto-repeats on the up/down keys) become one-clock events that drive a small
// counter. An active-low LED bar mirrors the counter.
//
// Key roles: key0 = up, key1 = down, key2 = clear, key3 = load PRESET.
// Keys above key3 only report state and events.
//
// Ports
//   clk          system clock
//   i_rst        asynchronous, active-high reset
//   i_sense      shared key return line, 0 = selected key pressed (asynchronous)
//   o_scan       key select, one bit low per scan slot
//   o_count      counter value
//   o_led        ~o_count, 0 = LED on
//   o_key_state  debounced key state, 1 = pressed
//   o_key_evt    one-clock pulse per accepted press or repeat
// -----------------------------------------------------------------------------
module scan_updown_counter #(
  parameter int NUM_KEYS       = 4,
  parameter int CNT_W          = 4,
  parameter int SCAN_DIV       = 4,
  parameter int DEB_SAMPLES    = 3,
  parameter int REPEAT_SAMPLES = 0,
  parameter int WRAP_MODE      = 1,
  parameter int PRESET         = 5
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_sense,
  output logic [NUM_KEYS-1:0] o_scan,
  output logic [CNT_W-1:0]    o_count,
  output logic [CNT_W-1:0]    o_led,
  output logic [NUM_KEYS-1:0] o_key_state,
  output logic [NUM_KEYS-1:0] o_key_evt
);

  localparam int SLOT_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int DCNT_W = $clog2(DEB_SAMPLES + 1);
  localparam int RCNT_W = (REPEAT_SAMPLES > 0) ? $clog2(REPEAT_SAMPLES + 1) : 1;

  localparam logic [SLOT_W-1:0]   LAST_SLOT = SLOT_W'(NUM_KEYS - 1);
  localparam logic [DIV_W-1:0]    LAST_DIV  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DCNT_W-1:0]   DEB_LAST  = DCNT_W'(DEB_SAMPLES - 1);
  localparam logic [RCNT_W-1:0]   RPT_LAST  = RCNT_W'(REPEAT_SAMPLES - 1);
  localparam logic [NUM_KEYS-1:0] SCAN_ONE  = NUM_KEYS'(1);
  localparam logic [CNT_W-1:0]    CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]    PRESET_V  = CNT_W'(PRESET);

  // Count arithmetic: wrap or saturate at the ends of the range.
  function automatic logic [CNT_W-1:0] step_up(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) return (WRAP_MODE != 0) ? '0 : CNT_MAX;
    return v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] step_down(input logic [CNT_W-1:0] v);
    if (v == '0) return (WRAP_MODE != 0) ? CNT_MAX : '0;
    return v - 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] apply_key(input logic [SLOT_W-1:0] key,
                                                 input logic [CNT_W-1:0]  v);
    if (key == SLOT_W'(0)) return step_up(v);
    if (key == SLOT_W'(1)) return step_down(v);
    if (key == SLOT_W'(2)) return '0;
    if (key == SLOT_W'(3)) return PRESET_V;
    return v;
  endfunction

  logic [SLOT_W-1:0]   slot;
  logic [DIV_W-1:0]    div;
  logic                sense_p0, sense_p1;
  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] evt;
  logic [CNT_W-1:0]    count;
  logic [DCNT_W-1:0]   dcnt [NUM_KEYS];
  logic [RCNT_W-1:0]   rcnt [NUM_KEYS];

  logic                cur_stable, nxt_stable, raw_pressed, is_rep_key, fire;
  logic [DCNT_W-1:0]   cur_dcnt, nxt_dcnt;
  logic [RCNT_W-1:0]   cur_rcnt, nxt_rcnt;

  // Per-sample decision for the key in the current slot. It is committed only
  // on the last clock of the slot.
  always_comb begin
    cur_stable  = stable[slot];
    cur_dcnt    = dcnt[slot];
    cur_rcnt    = rcnt[slot];
    raw_pressed = ~sense_p1;
    is_rep_key  = (slot == SLOT_W'(0)) || (slot == SLOT_W'(1));
    nxt_stable  = cur_stable;
    nxt_dcnt    = '0;
    nxt_rcnt    = cur_rcnt;
    fire        = 1'b0;

    // An agreeing sample clears the debounce count. A run of differing
    // samples flips the stable state.
    if (raw_pressed != cur_stable) begin
      if (cur_dcnt == DEB_LAST) nxt_stable = ~cur_stable;
      else                      nxt_dcnt   = cur_dcnt + 1'b1;
    end

    // A press or release restarts the repeat count. Only a press fires.
    if (nxt_stable != cur_stable) begin
      nxt_rcnt = '0;
      fire     = nxt_stable;
    end else if ((REPEAT_SAMPLES > 0) && cur_stable && is_rep_key) begin
      if (cur_rcnt == RPT_LAST) begin
        nxt_rcnt = '0;
        fire     = 1'b1;
      end else begin
        nxt_rcnt = cur_rcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      slot     <= '0;
      div      <= '0;
      o_scan   <= '1;
      sense_p0 <= 1'b1;
      sense_p1 <= 1'b1;
      stable   <= '0;
      evt      <= '0;
      count    <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        dcnt[k] <= '0;
        rcnt[k] <= '0;
      end
    end else begin
      // Synchroniser for the asynchronous return line.
      sense_p0 <= i_sense;
      sense_p1 <= sense_p0;
      // o_scan shows the slot one clock late. This lets the first clock after
      // reset drive slot 0 for a full SCAN_DIV clocks.
      o_scan   <= ~(SCAN_ONE << slot);
      evt      <= '0;
      if (div == LAST_DIV) begin
        div          <= '0;
        slot         <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;
        stable[slot] <= nxt_stable;
        dcnt[slot]   <= nxt_dcnt;
        rcnt[slot]   <= nxt_rcnt;
        if (fire) begin
          evt[slot] <= 1'b1;
          count     <= apply_key(slot, count);
        end
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  assign o_count     = count;
  assign o_led       = ~count;
  assign o_key_state = stable;
  assign o_key_evt   = evt;

endmodule
